// File: rtl/adder_pipe_scheduler_if.sv
// Bundles the requester, adder and response signals of adder_pipe_scheduler.
// The slave modport is the scheduler's view; the master modport is the surrounding system's view.
interface adder_pipe_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;

  logic [15:0]          add_a;
  logic [15:0]          add_b;
  logic                 add_cin;
  logic                 add_valid;
  logic [15:0]          add_sum;
  logic                 add_cout;

  logic                 rsp_valid;
  logic [2:0]           rsp_id;
  logic [15:0]          rsp_sum;
  logic                 rsp_cout;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout,
    output req_ready, add_a, add_b, add_cin, add_valid,
           rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout,
    input  req_ready, add_a, add_b, add_cin, add_valid,
           rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_pipe_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined 16-bit adder among NREQ requesters,
// tracking each op with a tag pipe and returning a registered, ID-tagged result.
module adder_pipe_scheduler #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 3,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  adder_pipe_scheduler_if.slave bus,
  output logic                 busy
);

  typedef struct packed {
    logic       vld;
    logic [2:0] id;
  } tag_t;

  logic [2:0]              rr_ptr_q, rr_ptr_d;
  tag_t [LATENCY-1:0]      tag_q, tag_d;
  logic [2:0]              outst_q [NREQ];
  logic [2:0]              outst_d [NREQ];
  logic                    rsp_valid_q, rsp_valid_d;
  logic [2:0]              rsp_id_q, rsp_id_d;
  logic [15:0]             rsp_sum_q, rsp_sum_d;
  logic                    rsp_cout_q, rsp_cout_d;

  logic [NREQ-1:0]         eligible;
  logic [NREQ-1:0]         grant;
  logic                    grant_vld;
  logic [2:0]              grant_idx;

  // Winner is the eligible index at the smallest rotational distance from rr_ptr.
  always_comb begin
    int best_d;
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    eligible  = '0;
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    best_d    = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      int d;
      eligible[i] = bus.req_valid[i] && (outst_q[i] < 3'(MAX_OUT)) && !hold && !reset;
      d = i - int'(rr_ptr_q);
      if (d < 0) d = d + NREQ;
      if (eligible[i] && (d < best_d)) begin
        best_d    = d;
        grant_idx = 3'(i);
        grant_vld = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = grant_vld && (grant_idx == 3'(i));
    end
  end

  always_comb begin
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        bus.add_a   = bus.req_a[16*i +: 16];
        bus.add_b   = bus.req_b[16*i +: 16];
        bus.add_cin = bus.req_cin[i];
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.add_valid = grant_vld;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == 3'(NREQ - 1)) ? 3'd0 : grant_idx + 3'd1;
    end

    tag_d[0].vld = grant_vld;
    tag_d[0].id  = grant_idx;
    for (int k = 1; k < LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    // The tag leaving the last stage lines up with the adder output sampled this edge.
    rsp_valid_d = tag_q[LATENCY-1].vld;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    if (tag_q[LATENCY-1].vld) begin
      rsp_id_d   = tag_q[LATENCY-1].id;
      rsp_sum_d  = bus.add_sum;
      rsp_cout_d = bus.add_cout;
    end

    // Issue and retire on the same edge for one requester cancel out.
    for (int i = 0; i < NREQ; i++) begin
      logic inc, dec;
      inc = grant[i];
      dec = rsp_valid_q && (rsp_id_q == 3'(i)) && (outst_q[i] != 3'd0);
      outst_d[i] = outst_q[i];
      if (inc && !dec) outst_d[i] = outst_q[i] + 3'd1;
      if (dec && !inc) outst_d[i] = outst_q[i] - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (reset) begin
      rr_ptr_q    <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      for (int i = 0; i < NREQ; i++) outst_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      for (int i = 0; i < NREQ; i++) outst_q[i] <= outst_d[i];
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (outst_q[i] != 3'd0) busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_pipe_scheduler.sv
// Directed bench for adder_pipe_scheduler: a behavioural 3-stage adder feeds the DUT and
// each scenario checks grants, response timing and data against hand-computed values.
module tb_adder_pipe_scheduler;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset;
  logic hold;
  logic busy;
  int   checks   = 0;
  int   failures = 0;

  logic [16:0] add_pipe [LAT];
  // {cout,sum} expected for requester i with the operand table loaded by load_table().
  logic [16:0] exp_res [NREQ] = '{17'h02345, 17'h10001, 17'h10000, 17'h0FFFF};

  adder_pipe_scheduler_if #(.NREQ(NREQ)) bus();

  adder_pipe_scheduler #(
    .NREQ(NREQ), .LATENCY(LAT), .MAX_OUT(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running adder: operands seen at edge E appear on its outputs for sampling at E+LAT.
  always @(posedge clk) begin
    add_pipe[0] <= 17'(bus.add_a) + 17'(bus.add_b) + 17'(bus.add_cin);
    for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign bus.add_sum  = add_pipe[LAT-1][15:0];
  assign bus.add_cout = add_pipe[LAT-1][16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
    bus.req_cin[i]        = c;
  endtask

  task automatic load_table();
    set_req(0, 16'h1234, 16'h1111, 1'b0);
    set_req(1, 16'h8000, 16'h8000, 1'b1);
    set_req(2, 16'hFFFF, 16'h0000, 1'b1);
    set_req(3, 16'h0F0F, 16'hF0F0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rsp_word();
    return 32'({bus.rsp_cout, bus.rsp_sum});
  endfunction

  initial begin
    reset         = 1'b1;
    hold          = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    step();
    step();

    // Reset state
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    check("rst_rsp_data",  rsp_word(),         32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_add_valid", 32'(bus.add_valid), 32'd0);
    reset = 1'b0;

    // Single op from requester 0: 0x00C8 + 0x0001 = 0x00C9
    set_req(0, 16'h00C8, 16'h0001, 1'b0);
    bus.req_valid = 4'b0001;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h1);
    check("single_add_a", 32'(bus.add_a),     32'h00C8);
    step();                                       // edge E
    bus.req_valid = '0;
    check("single_busy_e", 32'(busy), 32'd1);
    step();
    step();
    check("single_early", 32'(bus.rsp_valid), 32'd0);
    step();                                       // edge E+3
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("single_rsp_id",    32'(bus.rsp_id),    32'd0);
    check("single_rsp_data",  rsp_word(),         32'h000C9);
    step();                                       // edge E+4
    check("single_rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("single_busy_end", 32'(busy),           32'd0);

    // Carry case on requester 2: 0xFFFF + 0x0001 + 1 = 0x1_0001
    set_req(2, 16'hFFFF, 16'h0001, 1'b1);
    bus.req_valid = 4'b0100;
    #1;
    check("carry_ready", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = '0;
    step();
    step();
    step();
    check("carry_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("carry_rsp_id",    32'(bus.rsp_id),    32'd2);
    check("carry_rsp_data",  rsp_word(),         32'h10001);
    step();

    // All four requesters streaming: grants 0,1,2,3,... and gap-free ordered responses
    pulse_reset();
    load_table();
    bus.req_valid = 4'hF;
    #1;
    for (int n = 0; n < 11; n++) begin
      if (n < 8) check($sformatf("rr_grant_%0d", n), 32'(bus.req_ready), 32'(1 << (n % 4)));
      step();
      if (n == 7) bus.req_valid = '0;
      if (n >= 3) begin
        check($sformatf("rr_rsp_valid_%0d", n - 3), 32'(bus.rsp_valid), 32'd1);
        check($sformatf("rr_rsp_id_%0d", n - 3),    32'(bus.rsp_id),    32'((n - 3) % 4));
        check($sformatf("rr_rsp_data_%0d", n - 3),  rsp_word(),         32'(exp_res[(n - 3) % 4]));
      end
    end
    step();
    check("rr_rsp_idle", 32'(bus.rsp_valid), 32'd0);
    check("rr_busy_end", 32'(busy),          32'd0);

    // Outstanding limit of 2 with only requester 1 requesting
    pulse_reset();
    bus.req_valid = 4'b0010;
    #1;
    check("lim_ready_pre", 32'(bus.req_ready), 32'h2);
    step();                                       // E0: issue, outst=1
    check("lim_ready_e0", 32'(bus.req_ready), 32'h2);
    step();                                       // E1: issue, outst=2
    check("lim_ready_e1", 32'(bus.req_ready), 32'h0);
    step();                                       // E2
    check("lim_ready_e2", 32'(bus.req_ready), 32'h0);
    step();                                       // E3: first rsp registered
    check("lim_ready_e3",  32'(bus.req_ready), 32'h0);
    check("lim_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("lim_rsp_id",    32'(bus.rsp_id),    32'd1);
    check("lim_rsp_data",  rsp_word(),         32'h10001);
    step();                                       // E4: first rsp retires, outst=1
    check("lim_ready_e4", 32'(bus.req_ready), 32'h2);
    bus.req_valid = '0;
    step();
    check("lim_busy_end", 32'(busy), 32'd0);

    // hold after two issues: grants stop, in-flight results return, pointer frozen
    pulse_reset();
    bus.req_valid = 4'b0111;
    #1;
    check("hold_grant0", 32'(bus.req_ready), 32'h1);
    step();                                       // E0
    check("hold_grant1", 32'(bus.req_ready), 32'h2);
    step();                                       // E1
    hold = 1'b1;
    #1;
    check("hold_ready_now", 32'(bus.req_ready), 32'h0);
    check("hold_add_valid", 32'(bus.add_valid), 32'd0);
    for (int c = 2; c <= 6; c++) begin
      step();
      check($sformatf("hold_ready_e%0d", c), 32'(bus.req_ready), 32'h0);
      check($sformatf("hold_rsp_valid_e%0d", c), 32'(bus.rsp_valid), 32'((c == 3) || (c == 4)));
      if (c == 3) check("hold_rsp_id_a", 32'(bus.rsp_id), 32'd0);
      if (c == 4) begin
        check("hold_rsp_id_b",   32'(bus.rsp_id), 32'd1);
        check("hold_rsp_data_b", rsp_word(),      32'h10001);
      end
    end
    check("hold_busy_drained", 32'(busy), 32'd0);
    hold = 1'b0;
    #1;
    check("hold_resume_grant", 32'(bus.req_ready), 32'h4);
    step();                                       // issues requester 2, pointer -> 3
    bus.req_valid = '0;
    for (int c = 0; c < 5; c++) step();
    check("hold_busy_end", 32'(busy), 32'd0);

    // Reset one cycle after three issues discards all in-flight ops
    bus.req_valid = 4'hF;
    #1;
    check("rst_mid_grant0", 32'(bus.req_ready), 32'h8);
    step();
    check("rst_mid_grant1", 32'(bus.req_ready), 32'h1);
    step();
    check("rst_mid_grant2", 32'(bus.req_ready), 32'h2);
    step();                                       // third issue, pointer -> 2
    reset         = 1'b1;
    bus.req_valid = 4'b0110;
    #1;
    check("rst_mid_ready_in_reset", 32'(bus.req_ready), 32'h0);
    step();
    reset = 1'b0;
    #1;
    check("rst_mid_busy",      32'(busy),          32'd0);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_ready_ptr", 32'(bus.req_ready), 32'h2);
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rst_mid_no_rsp_%0d", c), 32'(bus.rsp_valid), 32'd0);
    end
    check("rst_mid_busy_end", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
